// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the nibble-serial 74181 sequencer.
// The state encoding and field widths live here so users can decode them.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int NIBBLE_W = 4;
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Drives one shared 4-bit 74181 slice nibble by nibble, LSB first,
// chaining Cn+4 between steps and returning the assembled WIDTH-bit result.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_s,
  input  logic             req_m,
  input  logic             req_cn,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn4,
  input  logic             alu_equal,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout,
  output logic             rsp_equal,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIBBLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

  state_e              state_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    f_q;
  logic [3:0]          s_q;
  logic                m_q;
  logic                carry_q;
  logic                eq_q;
  logic [NIB_W-1:0]    nib_q;
  logic [SETTLE_W-1:0] wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      nib_q   <= '0;
      wait_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            s_q     <= req_s;
            m_q     <= req_m;
            carry_q <= req_cn;
            eq_q    <= 1'b1;
            nib_q   <= '0;
            wait_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (wait_q != SETTLE_V) begin
            wait_q <= wait_q + 1'b1;
          end else begin
            for (int i = 0; i < NIBBLES; i++) begin
              if (nib_q == NIB_W'(i))
                f_q[i*NIBBLE_W +: NIBBLE_W] <= alu_f;
            end
            carry_q <= alu_cn4;
            eq_q    <= eq_q & alu_equal;
            wait_q  <= '0;
            if (nib_q == NIB_LAST)
              state_q <= DONE;
            else
              nib_q <= nib_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand nibbles are only shown to the slice while a job is running.
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (nib_q == NIB_W'(i)) begin
          alu_a = a_q[i*NIBBLE_W +: NIBBLE_W];
          alu_b = b_q[i*NIBBLE_W +: NIBBLE_W];
        end
      end
    end
  end

  assign alu_s     = s_q;
  assign alu_m     = m_q;
  assign alu_cn    = carry_q;
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_f     = f_q;
  assign rsp_cout  = carry_q;
  assign rsp_equal = eq_q;

endmodule
